// File: rtl/uart_pkg.sv
// Shared constants and FSM state encodings for the uart_core block.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/uart_core_sync_fifo.sv
// Show-ahead synchronous FIFO; pointers carry one extra wrap bit so
// occupancy is a plain subtraction.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] PTR_ONE  = (AW + 1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_wr, do_rd;

    assign count   = wr_ptr_q - rd_ptr_q;
    assign full    = (count == FULL_LVL);
    assign empty   = (count == '0);
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    // A pop frees the slot the same cycle, so a push alongside a pop is accepted even when full.
    always_comb begin
        do_rd    = rd_en && !empty;
        do_wr    = wr_en && (!full || do_rd);
        wr_ptr_d = do_wr ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/uart_core.sv
// UART with runtime baud divisor, optional parity, 1/2 stop bits,
// TX/RX FIFOs, RX level threshold and sticky error flags.
module uart_core
    import uart_pkg::*;
#(
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_W     = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [DIV_W-1:0]              baud_div,
    input  logic                          parity_en,
    input  logic                          parity_odd,
    input  logic                          stop2,
    input  logic [$clog2(FIFO_DEPTH):0]   rx_thresh,
    input  logic                          rx,
    output logic                          tx,
    input  logic                          tx_wr_en,
    input  logic [DATA_W-1:0]             tx_wr_data,
    output logic                          tx_full,
    output logic                          tx_busy,
    input  logic                          rx_rd_en,
    output logic [DATA_W-1:0]             rx_rd_data,
    output logic                          rx_empty,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          rx_thresh_hit,
    input  logic                          err_clr,
    output logic                          err_frame,
    output logic                          err_parity,
    output logic                          err_overrun
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_W);
    localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] MID_TICK  = TW'(MID_SAMPLE);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);

    logic [DIV_W-1:0]  baud_cnt_q, baud_cnt_d;
    logic              tick;

    tx_state_e         tx_state_q, tx_state_d;
    logic [TW-1:0]     tx_tick_q, tx_tick_d;
    logic [BW-1:0]     tx_bit_q, tx_bit_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic              tx_par_bit_q, tx_par_bit_d;
    logic              tx_par_en_q, tx_par_en_d;
    logic              tx_stop2_q, tx_stop2_d;
    logic              tx_stop_cnt_q, tx_stop_cnt_d;
    logic              tx_line_q, tx_line_d;
    logic              tx_end, tx_load;

    logic              txf_rd, txf_empty;
    logic [DATA_W-1:0] txf_rd_data;
    logic [CW-1:0]     txf_count;

    logic              rx_s1_q, rx_s2_q, rx_s3_q;
    rx_state_e         rx_state_q, rx_state_d;
    logic [TW-1:0]     rx_tick_q, rx_tick_d;
    logic [BW-1:0]     rx_bit_q, rx_bit_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic              rx_par_q, rx_par_d;
    logic              rx_end, rx_fall;
    logic              rxf_wr, rxf_full;

    logic              set_frame, set_parity, set_overrun;
    logic              err_frame_q, err_frame_d;
    logic              err_parity_q, err_parity_d;
    logic              err_overrun_q, err_overrun_d;

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (tx_wr_en),
        .wr_data (tx_wr_data),
        .rd_en   (txf_rd),
        .rd_data (txf_rd_data),
        .full    (tx_full),
        .empty   (txf_empty),
        .count   (txf_count)
    );

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (rxf_wr),
        .wr_data (rx_shift_q),
        .rd_en   (rx_rd_en),
        .rd_data (rx_rd_data),
        .full    (rxf_full),
        .empty   (rx_empty),
        .count   (rx_count)
    );

    assign tick          = (baud_cnt_q == '0);
    assign tx            = tx_line_q;
    assign tx_busy       = (txf_count != '0) || (tx_state_q != TX_IDLE);
    assign rx_thresh_hit = (rx_thresh != '0) && (rx_count >= rx_thresh);
    assign err_frame     = err_frame_q;
    assign err_parity    = err_parity_q;
    assign err_overrun   = err_overrun_q;

    always_comb begin
        baud_cnt_d = tick ? baud_div : baud_cnt_q - DIV_W'(1);
    end

    // The 4-bit tick counter wraps every 16 ticks, so a bit ends whenever it ticks at 15.
    always_comb begin
        tx_state_d    = tx_state_q;
        tx_tick_d     = tick ? tx_tick_q + TICK_ONE : tx_tick_q;
        tx_bit_d      = tx_bit_q;
        tx_shift_d    = tx_shift_q;
        tx_par_bit_d  = tx_par_bit_q;
        tx_par_en_d   = tx_par_en_q;
        tx_stop2_d    = tx_stop2_q;
        tx_stop_cnt_d = tx_stop_cnt_q;
        tx_line_d     = tx_line_q;
        tx_end        = tick && (tx_tick_q == LAST_TICK);
        tx_load       = 1'b0;
        txf_rd        = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                tx_line_d = 1'b1;
                tx_tick_d = '0;
                tx_load   = !txf_empty;
            end
            TX_START: begin
                if (tx_end) begin
                    tx_state_d = TX_DATA;
                    tx_bit_d   = '0;
                    tx_line_d  = tx_shift_q[0];
                end
            end
            TX_DATA: begin
                if (tx_end) begin
                    if (tx_bit_q == LAST_BIT) begin
                        tx_state_d    = tx_par_en_q ? TX_PARITY : TX_STOP;
                        tx_line_d     = tx_par_en_q ? tx_par_bit_q : 1'b1;
                        tx_stop_cnt_d = 1'b0;
                    end else begin
                        tx_bit_d   = tx_bit_q + BIT_ONE;
                        tx_shift_d = tx_shift_q >> 1;
                        tx_line_d  = tx_shift_q[1];
                    end
                end
            end
            TX_PARITY: begin
                if (tx_end) begin
                    tx_state_d    = TX_STOP;
                    tx_line_d     = 1'b1;
                    tx_stop_cnt_d = 1'b0;
                end
            end
            TX_STOP: begin
                if (tx_end) begin
                    if (tx_stop2_q && !tx_stop_cnt_q) begin
                        tx_stop_cnt_d = 1'b1;
                    end else if (!txf_empty) begin
                        tx_load = 1'b1;
                    end else begin
                        tx_state_d = TX_IDLE;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
        if (tx_load) begin
            txf_rd        = 1'b1;
            tx_shift_d    = txf_rd_data;
            tx_par_bit_d  = (^txf_rd_data) ^ parity_odd;
            tx_par_en_d   = parity_en;
            tx_stop2_d    = stop2;
            tx_stop_cnt_d = 1'b0;
            tx_tick_d     = '0;
            tx_line_d     = 1'b0;
            tx_state_d    = TX_START;
        end
    end

    // RX sampling is anchored at mid-start; each later sample lands 16 ticks on.
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_tick_d   = tick ? rx_tick_q + TICK_ONE : rx_tick_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_par_d    = rx_par_q;
        rx_fall     = rx_s3_q && !rx_s2_q;
        rx_end      = tick && (rx_tick_q == LAST_TICK);
        rxf_wr      = 1'b0;
        set_frame   = 1'b0;
        set_parity  = 1'b0;
        set_overrun = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_tick_d = '0;
                if (rx_fall) begin
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (tick && (rx_tick_q == MID_TICK)) begin
                    rx_tick_d  = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_end) begin
                    rx_shift_d = {rx_s2_q, rx_shift_q[DATA_W-1:1]};
                    if (rx_bit_q == LAST_BIT) begin
                        rx_state_d = parity_en ? RX_PARITY : RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + BIT_ONE;
                    end
                end
            end
            RX_PARITY: begin
                if (rx_end) begin
                    rx_par_d   = rx_s2_q;
                    rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_end) begin
                    rx_state_d = RX_IDLE;
                    if (!rx_s2_q) begin
                        set_frame = 1'b1;
                    end else if (parity_en && (((^rx_shift_q) ^ parity_odd) != rx_par_q)) begin
                        set_parity = 1'b1;
                    end else if (rxf_full && !rx_rd_en) begin
                        set_overrun = 1'b1;
                    end else begin
                        rxf_wr = 1'b1;
                    end
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        err_frame_d   = set_frame   || (err_frame_q   && !err_clr);
        err_parity_d  = set_parity  || (err_parity_q  && !err_clr);
        err_overrun_d = set_overrun || (err_overrun_q && !err_clr);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            baud_cnt_q    <= '0;
            tx_state_q    <= TX_IDLE;
            tx_tick_q     <= '0;
            tx_bit_q      <= '0;
            tx_shift_q    <= '0;
            tx_par_bit_q  <= 1'b0;
            tx_par_en_q   <= 1'b0;
            tx_stop2_q    <= 1'b0;
            tx_stop_cnt_q <= 1'b0;
            tx_line_q     <= 1'b1;
            rx_s1_q       <= 1'b1;
            rx_s2_q       <= 1'b1;
            rx_s3_q       <= 1'b1;
            rx_state_q    <= RX_IDLE;
            rx_tick_q     <= '0;
            rx_bit_q      <= '0;
            rx_shift_q    <= '0;
            rx_par_q      <= 1'b0;
            err_frame_q   <= 1'b0;
            err_parity_q  <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            baud_cnt_q    <= baud_cnt_d;
            tx_state_q    <= tx_state_d;
            tx_tick_q     <= tx_tick_d;
            tx_bit_q      <= tx_bit_d;
            tx_shift_q    <= tx_shift_d;
            tx_par_bit_q  <= tx_par_bit_d;
            tx_par_en_q   <= tx_par_en_d;
            tx_stop2_q    <= tx_stop2_d;
            tx_stop_cnt_q <= tx_stop_cnt_d;
            tx_line_q     <= tx_line_d;
            rx_s1_q       <= rx;
            rx_s2_q       <= rx_s1_q;
            rx_s3_q       <= rx_s2_q;
            rx_state_q    <= rx_state_d;
            rx_tick_q     <= rx_tick_d;
            rx_bit_q      <= rx_bit_d;
            rx_shift_q    <= rx_shift_d;
            rx_par_q      <= rx_par_d;
            err_frame_q   <= err_frame_d;
            err_parity_q  <= err_parity_d;
            err_overrun_q <= err_overrun_d;
        end
    end

endmodule

// File: doc/uart_core.md
Name: uart_core

Overview:
- Parametrised successor to the fixed 8N1 UART subsystem; one block holds the baud generator, TX and RX engines, and TX and RX FIFOs.
- Adds runtime baud divisor, optional even/odd parity, 1 or 2 stop bits, a TX FIFO, a programmable RX threshold, and sticky error flags.
- Sits between the SoC bus register wrapper and the pad-level rx/tx lines.

Parameters:
- DIV_W, 16, width of the oversample divisor.
- FIFO_DEPTH, 16, entries per FIFO; power of two, at least 4.
- DATA_W, 8, data bits per frame; legal range 5..8.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- baud_div  in  DIV_W  oversample tick period minus 1; one bit lasts 16 ticks.
- parity_en  in  1  1 = parity bit present.
- parity_odd  in  1  1 = odd parity, 0 = even parity.
- stop2  in  1  1 = two stop bits.
- rx_thresh  in  $clog2(FIFO_DEPTH)+1  RX level that asserts rx_thresh_hit.
- rx  in  1  serial input, asynchronous to clk.
- tx  out  1  serial output, idles high.
- tx_wr_en  in  1  push tx_wr_data into the TX FIFO.
- tx_wr_data  in  DATA_W  byte to send.
- tx_full  out  1  TX FIFO full.
- tx_busy  out  1  TX FIFO not empty, or a frame is in flight.
- rx_rd_en  in  1  pop the RX FIFO.
- rx_rd_data  out  DATA_W  RX FIFO head (show-ahead).
- rx_empty  out  1  RX FIFO empty.
- rx_count  out  $clog2(FIFO_DEPTH)+1  RX FIFO occupancy.
- rx_thresh_hit  out  1  rx_count >= rx_thresh and rx_thresh != 0.
- err_clr  in  1  clears all sticky error flags.
- err_frame, err_parity, err_overrun  out  1 each  sticky error flags.

Behaviour:
- Reset (async assert, sync deassert effect):
  - tx=1; tx_busy=0; tx_full=0; rx_empty=1; rx_count=0; rx_rd_data=0; all error flags 0; both FSMs IDLE; FIFO pointers 0.
  - A reset mid-frame drives tx high in the same instant and discards any partial frame.
- Baud generator:
  - Down-counter reloads baud_div and emits a 1-cycle tick at 0, so tick period = baud_div+1 clocks.
  - A new baud_div takes effect at the next reload.
- TX FIFO:
  - A write while full is dropped with no error.
  - Write and read in the same cycle are both legal at any level.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE->START when the FIFO is non-empty: pop, latch the byte plus parity_en/parity_odd/stop2 for the whole frame, drive tx=0.
  - Each state holds for 16 ticks.
  - DATA sends LSB first, DATA_W bits.
  - PARITY sends XOR(data) ^ parity_odd; the state is skipped if parity_en=0.
  - STOP drives tx=1 for 1 or 2 bit times, then returns to IDLE; a non-empty FIFO restarts START directly with no idle bit.
- RX input: 2-flop synchroniser on rx. Edge detection uses the synchronised value only.
- RX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE->START on a synchronised falling edge; tick counter cleared.
  - START: at tick 7 (mid-bit), a line still at 0 goes to DATA; a line at 1 is a glitch and returns to IDLE.
  - DATA/PARITY: sample at every 16th tick after mid-start.
  - STOP: sample once, even when stop2=1; RX accepts 1 stop bit.
- RX frame completion:
  - stop=0: set err_frame, discard byte.
  - Parity mismatch: set err_parity, discard byte.
  - Otherwise, if the RX FIFO is full: set err_overrun, discard byte; else push.
  - The FSM returns to IDLE at stop mid-bit, so back-to-back frames are tolerated.
- RX FIFO:
  - rx_rd_data is valid whenever rx_empty=0.
  - A pop when empty is ignored.
  - A push and a pop in the same cycle keep rx_count unchanged, including at full.
  - Push-to-visibility latency: 1 clock.
- Errors:
  - A flag sets on its event and clears on err_clr.
  - If set and clear coincide, set wins.
- Arithmetic: occupancy is wr_ptr - rd_ptr on $clog2(FIFO_DEPTH)+1-bit pointers; wrap by natural overflow.

Decomposition:
- Shared package uart_pkg holds:
  - OVERSAMPLE = 16;
  - TX/RX state enums;
  - the mid-bit sample index constant 7.
- One sub-module, sync_fifo (params WIDTH, DEPTH; show-ahead; outputs full, empty, count), instantiated twice.
- The baud counter and both FSMs stay in uart_core.

Test Plan:
- baud_div=0, 8N1, write 0xA5 -> tx line: start 0, bits 1,0,1,0,0,1,0,1, stop 1; each bit 16 clocks; frame is 160 clocks; then tx_busy falls.
- Loopback tx->rx, parity_en=1, parity_odd=1, write 0x00,0xFF,0x3C -> RX reads the same three bytes; err_parity=0; parity bit on line is 1,1,1.
- Drive a frame on rx with stop bit=0 -> err_frame=1, rx_empty stays 1; err_clr pulse -> err_frame=0.
- FIFO_DEPTH=4, rx_thresh=3, receive 5 bytes without reading -> rx_thresh_hit rises at the 3rd byte; rx_count=4; err_overrun=1; reads return bytes 1-4 in order.
- Glitch: rx low for 4 ticks -> no byte, no error, FSM back to IDLE.
- Assert reset_n=0 mid-TX data bit -> tx=1 immediately; after release, tx_busy=0 and all flags 0.
